// File: rtl/riscky_pkg.sv
// Shared types and constants for the riscky core: data width, fetch FSM
// states and the major opcodes decoded by control.
package riscky_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue holding {pc, instr}; the head is read straight
// out of register storage so nothing upstream reaches it combinationally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues word reads under a credit limit of DEPTH,
// queues returned instructions and handles taken-branch redirects.
module fetch_unit
  import riscky_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output fetch_state_t    dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = CW + 1;

  fetch_state_t      state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [XLEN-1:0]   redirect_target;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_nxt;
  logic [CW-1:0]     drop_cnt;
  logic [LW-1:0]     in_use;
  logic [LW-1:0]     credit_limit;
  logic              req_fire;
  logic              rsp_fire;
  logic              pop;
  logic              push;
  logic [2*XLEN-1:0] head;

  // Both channels transfer on a cycle where valid and ready are high together;
  // valid never depends on the same channel's ready, and responses are never stalled.
  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_fire = imem_rsp_valid;
  assign pop      = instr_valid & instr_ready;
  assign push     = rsp_fire && (drop_cnt == '0) && !redirect_valid;

  // An entry leaving the queue this cycle frees a slot for a request this cycle.
  assign in_use         = LW'(count) + LW'(outstanding);
  assign credit_limit   = LW'(DEPTH) + LW'(pop);
  assign imem_req_valid = (state == FETCH) && (in_use < credit_limit);
  assign imem_req_addr  = fetch_pc;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_fire);
  assign redirect_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path.
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        drop_cnt <= outstanding_nxt;
        state    <= (outstanding_nxt == '0) ? FETCH : FLUSH;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_fire) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
          else                rsp_pc   <= rsp_pc + XLEN'(4);
        end
        case (state)
          BOOT:    state <= FETCH;
          FLUSH:   if (drop_cnt == '0 || (rsp_fire && drop_cnt == CW'(1))) state <= FETCH;
          default: state <= state;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign instr_valid = (count != '0);
  assign instr       = head[XLEN-1:0];
  assign instr_pc    = head[2*XLEN-1:XLEN];
  assign op          = head[6:0];
  assign funct3      = head[14:12];
  assign funct7      = head[31:25];
  assign dbg_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, scoreboard of expected
// {pc, instr} pairs and one task per scenario.
module tb_fetch_unit;
  import riscky_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic         clk            = 1'b0;
  logic         rst_n          = 1'b0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [31:0]  imem_rsp_data  = 32'h0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc    = 32'h0;
  logic         instr_valid;
  logic         instr_ready    = 1'b0;
  logic [31:0]  instr;
  logic [31:0]  instr_pc;
  logic [6:0]   op;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  fetch_state_t dbg_state;

  int           n_cmp     = 0;
  int           n_fail    = 0;
  int           req_total = 0;
  int           pop_total = 0;
  logic [63:0]  exp_q[$];
  logic [31:0]  mem_pend[$];
  logic [31:0]  exp_addr  = RESET_PC;
  logic [63:0]  mon_e;
  logic         mon_en    = 1'b0;
  logic         rsp_hold  = 1'b0;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op             (op),
    .funct3         (funct3),
    .funct7         (funct7),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_for(input logic [31:0] a);
    logic [6:0] opc;
    case (a[4:2])
      3'd0:    opc = OP_LOAD;
      3'd1:    opc = OP_STORE;
      3'd2:    opc = OP_RTYPE;
      3'd3:    opc = OP_ITYPE;
      default: opc = OP_BRANCH;
    endcase
    return {a[31:7] ^ 25'h15A5A5A, opc};
  endfunction

  // ---------------- memory model: in order, one-cycle latency ----------------
  always @(negedge clk) begin
    if (!rst_n) mem_pend.delete();
    else if (imem_req_valid && imem_req_ready) mem_pend.push_back(imem_req_addr);
  end

  always @(posedge clk) begin
    #2;
    if (rst_n && !rsp_hold && mem_pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_for(mem_pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (instr_valid && instr_ready) begin
        pop_total++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr);
        end else begin
          mon_e = exp_q.pop_front();
          if ({instr_pc, instr} !== mon_e) begin
            n_fail++;
            $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                     instr_pc, instr, mon_e[63:32], mon_e[31:0]);
          end
          n_cmp++;
          if ({funct7, funct3, op} !== {mon_e[31:25], mon_e[14:12], mon_e[6:0]}) begin
            n_fail++;
            $display("FAIL pop_fields: got f7=%h f3=%h op=%h, required f7=%h f3=%h op=%h",
                     funct7, funct3, op, mon_e[31:25], mon_e[14:12], mon_e[6:0]);
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        req_total++;
        n_cmp++;
        if (imem_req_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL req_addr: got %h, required %h", imem_req_addr, exp_addr);
        end
        exp_q.push_back({exp_addr, instr_for(exp_addr)});
        exp_addr = exp_addr + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_addr = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b1;
    rsp_hold       = 1'b0;
    redirect_valid = 1'b0;
    while ((exp_q.size() != 0 || mem_pend.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || mem_pend.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d expected entries left, required 0", exp_q.size());
    end
    n_cmp++;
    if ({instr_valid, dbg_state} !== {1'b0, FETCH}) begin
      n_fail++;
      $display("FAIL drain_idle: got valid=%b state=%0d, required valid=0 state=%0d",
               instr_valid, dbg_state, FETCH);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr} !== {1'b0, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_req: got valid=%b addr=%h, required valid=0 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    n_cmp++;
    if ({instr_valid, instr, instr_pc} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_instr: got valid=%b instr=%h pc=%h, required all zero", instr_valid, instr, instr_pc);
    end
    n_cmp++;
    if ({op, funct3, funct7, dbg_state} !== {17'h0, BOOT}) begin
      n_fail++;
      $display("FAIL reset_fields: got op=%h f3=%h f7=%h state=%0d, required zero fields, state BOOT", op, funct3, funct7, dbg_state);
    end
    exp_q.delete();
    exp_addr = RESET_PC;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_no_req: got valid=%b, required 0", imem_req_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL first_req: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int pops = 0;
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (4) @(posedge clk);
    repeat (16) begin
      @(negedge clk);
      if (instr_valid && instr_ready) pops++;
    end
    n_cmp++;
    if (pops !== 16) begin
      n_fail++;
      $display("FAIL throughput: got %0d instructions in 16 cycles, required 16", pops);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int req0;
    int pop0;
    @(posedge clk); #1;
    req0           = req_total;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({imem_req_valid, instr_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL stall_valids: got req_valid=%b instr_valid=%b, required 0 and 1", imem_req_valid, instr_valid);
    end
    n_cmp++;
    if (req_total - req0 !== DEPTH) begin
      n_fail++;
      $display("FAIL stall_requests: got %0d requests, required %0d", req_total - req0, DEPTH);
    end
    pop0 = pop_total;
    drain();
    n_cmp++;
    if (pop_total - pop0 !== DEPTH) begin
      n_fail++;
      $display("FAIL stall_release: got %0d instructions, required %0d", pop_total - pop0, DEPTH);
    end
  endtask

  task automatic test_redirect_flush();
    int n = 0;
    @(posedge clk); #1;
    rsp_hold       = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_limit: got req_valid=%b with %0d outstanding, required 0", imem_req_valid, DEPTH);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    n_cmp++;
    if ({dbg_state, imem_req_valid, instr_valid} !== {FLUSH, 2'b00}) begin
      n_fail++;
      $display("FAIL flush_enter: got state=%0d req=%b valid=%b, required FLUSH 0 0", dbg_state, imem_req_valid, instr_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dbg_state !== FLUSH) begin
      n_fail++;
      $display("FAIL flush_hold: got state=%0d after one drop, required FLUSH", dbg_state);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({dbg_state, imem_req_valid, imem_req_addr} !== {FETCH, 1'b1, 32'h0000_0100}) begin
      n_fail++;
      $display("FAIL flush_exit: got state=%0d req=%b addr=%h, required FETCH 1 00000100", dbg_state, imem_req_valid, imem_req_addr);
    end
    while (!instr_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'h0000_0100}) begin
      n_fail++;
      $display("FAIL redirect_first_pc: got valid=%b pc=%h, required 1 00000100", instr_valid, instr_pc);
    end
    drain();
  endtask

  task automatic test_redirect_collision();
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #2;
    n_cmp++;
    if ({imem_req_valid, imem_rsp_valid, instr_valid} !== 3'b111) begin
      n_fail++;
      $display("FAIL collision_setup: got req=%b rsp=%b valid=%b, required 111", imem_req_valid, imem_rsp_valid, instr_valid);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++;
    if ({dbg_state, instr_valid} !== {FLUSH, 1'b0}) begin
      n_fail++;
      $display("FAIL collision_drop: got state=%0d valid=%b, required FLUSH 0", dbg_state, instr_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({dbg_state, imem_req_valid, imem_req_addr} !== {FETCH, 1'b1, 32'h0000_0200}) begin
      n_fail++;
      $display("FAIL collision_restart: got state=%0d req=%b addr=%h, required FETCH 1 00000200", dbg_state, imem_req_valid, imem_req_addr);
    end
    repeat (6) @(posedge clk);
    drain();
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    n_cmp++;
    if ({dbg_state, imem_req_valid, imem_req_addr} !== {FETCH, 1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_start: got state=%0d req=%b addr=%h, required FETCH 1 fffffffc", dbg_state, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: got addr=%h, required 00000000", imem_req_addr);
    end
    repeat (4) @(posedge clk);
    drain();
  endtask

  task automatic test_random();
    repeat (300) begin
      @(posedge clk); #1;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      rsp_hold       = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom();
      end else begin
        redirect_valid = 1'b0;
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({instr_valid, imem_req_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midreset_setup: got valid=%b req=%b, required full queue (1 0)", instr_valid, imem_req_valid);
    end
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc} !== {1'b0, RESET_PC, 65'h0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got req=%b addr=%h valid=%b instr=%h pc=%h, required reset values",
               imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc);
    end
    n_cmp++;
    if ({op, funct3, funct7, dbg_state} !== {17'h0, BOOT}) begin
      n_fail++;
      $display("FAIL midreset_fields: got op=%h f3=%h f7=%h state=%0d, required zero fields, state BOOT", op, funct3, funct7, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_addr    = RESET_PC;
    instr_ready = 1'b1;
    rst_n       = 1'b1;
    mon_en      = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL midreset_restart: got req=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    repeat (8) @(posedge clk);
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collision();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the riscky core: owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions in a small in-order queue. Buffered instructions are presented to the decode/control stage with a valid/ready handshake, together with their PC and the op/funct3/funct7 fields. A taken-branch redirect from execute flushes the queue, discards in-flight responses and restarts fetch at the new PC.

## Interface
Clock is `clk`; reset is `rst_n`, asynchronous and active-low.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction queue entries; also the maximum number of outstanding requests (power of two, ≥2)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address, bits [1:0] always 0
- `imem_rsp_valid`  in  1  response valid, in order, no backpressure
- `imem_rsp_data`  in  32  instruction word
- `redirect_valid`  in  1  taken branch/jump, single-cycle pulse
- `redirect_pc`  in  32  new PC, bits [1:0] ignored
- `instr_valid`  out  1  queue head valid
- `instr_ready`  in  1  decode consumes head
- `instr`  out  32  head instruction
- `instr_pc`  out  32  head PC
- `op`  out  7  instr[6:0]
- `funct3`  out  3  instr[14:12]
- `funct7`  out  7  instr[31:25]

## Operation
- FSM states BOOT, FETCH, FLUSH. Reset → BOOT; BOOT → FETCH after one cycle (no request in BOOT).
- FETCH: `imem_req_valid` = 1 while (queue count + outstanding) < DEPTH. Handshake (valid & ready) increments outstanding; fetch PC += 4 (wraps 32'hFFFF_FFFC → 0).
- Response: if drop_cnt = 0, push {data, PC} into queue; otherwise discard and decrement drop_cnt. Either way, decrement outstanding. Response PC is tracked by a parallel in-order PC queue or an equivalent mechanism.
- Redirect (any state):
  - Queue cleared; fetch PC ← {redirect_pc[31:2], 2'b00}.
  - drop_cnt ← outstanding after this cycle's handshake/response.
  - If drop_cnt would be 0 → FETCH, else → FLUSH.
- FLUSH: no requests; responses are discarded. At the cycle drop_cnt reaches 0, go to FETCH.
- Simultaneous events in a redirect cycle:
  - A request accepted that cycle counts as outstanding and is dropped.
  - A response arriving that cycle is discarded and not counted in drop_cnt.
  - A decode handshake that cycle completes normally (the consumed instruction is valid).
- Queue never overflows: the credit rule above guarantees space for every response.

## Timing
- Reset values:
  - `imem_req_valid` 0, `imem_req_addr` RESET_PC
  - `instr_valid` 0, `instr` 0, `instr_pc` 0, op/funct3/funct7 0
  - count, outstanding and drop_cnt all 0
- First request is at the second rising edge after reset deassertion.
- Response accepted at edge N gives `instr_valid` from cycle N+1. There is no combinational path from imem_rsp_* to instr_*.
- `instr_valid` drops in the cycle after a redirect. The first new request goes out in the cycle after the redirect when drop_cnt = 0.
- Queue push and pop in the same cycle keep the count unchanged. A full queue with a pop in the same cycle may accept a new request that cycle.
- `rst_n` asserted mid-operation immediately returns every output to its reset value. Responses still in flight after reset release are the memory's responsibility.

## Structure
- riscky_pkg gains:
  - `XLEN` = 32
  - the `fetch_state_t` enum {BOOT, FETCH, FLUSH}
  - opcode constants OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_RTYPE 7'b0110011, OP_ITYPE 7'b0010011, OP_BRANCH 7'b1100011, shared with control
- Sub-module `fetch_fifo`: synchronous FIFO, parameter DEPTH, width 64 ({pc, instr}). Provides push, pop, flush, count, and head outputs registered from storage.

## Test plan
- Reset release, memory ready=1 with 1-cycle latency, decode ready=1 → addresses 0x0, 0x4, 0x8…; `instr_pc` tracks; steady throughput of 1 instr/cycle.
- Decode ready=0 → at most DEPTH requests issued, then `imem_req_valid`=0; release ready → the DEPTH instructions come out in order with no loss.
- Redirect to 0x100 with 2 outstanding → next 2 responses discarded; FLUSH lasts until the second; first instr_pc after redirect is 0x100.
- Redirect in the same cycle as a request handshake and a response → drop_cnt correct; no stale instruction appears.
- redirect_pc = 0x203 → request address 0x200. Fetch from 0xFFFF_FFFC → next address 0x0.
- Assert rst_n mid-stream with a full queue → all outputs at reset values asynchronously; fetch restarts at RESET_PC.
